// File: rtl/ift_sram_arb_pkg.sv
// Shared types for the taint-tracking SRAM arbiter: requester index and response register.
package ift_sram_arb_pkg;

    localparam int unsigned MaxNumReq = 8;
    localparam int unsigned IdxWidth  = $clog2(MaxNumReq);

    typedef logic [IdxWidth-1:0] req_idx_t;

    typedef struct packed {
        logic     valid;
        req_idx_t id;
        logic     taint;
    } resp_t;

    // Round-robin successor of a granted index, wrapping at n.
    function automatic req_idx_t next_ptr(input req_idx_t idx, input int unsigned n);
        return (32'(idx) + 32'd1 >= n) ? '0 : idx + IdxWidth'(1);
    endfunction

endpackage

// File: rtl/ift_rr_picker.sv
// Round-robin picker: first set request at or after ptr_i, wrapping modulo NumReq.
module ift_rr_picker
    import ift_sram_arb_pkg::*;
#(
    parameter int unsigned NumReq = 2
) (
    input  logic [NumReq-1:0] req_i,
    input  req_idx_t          ptr_i,
    output logic [NumReq-1:0] gnt_o,
    output req_idx_t          idx_o,
    output logic              valid_o
);

    int unsigned       cand;
    logic [NumReq-1:0] shifted;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        shifted = '0;
        for (int unsigned off = 0; off < NumReq; off++) begin
            cand    = (32'(ptr_i) + off) % NumReq;
            shifted = req_i >> cand;
            if (!valid_o && shifted[0]) begin
                valid_o = 1'b1;
                gnt_o   = NumReq'(1) << cand;
                idx_o   = IdxWidth'(cand);
            end
        end
    end

endmodule

// File: rtl/ift_sram_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency SRAM port, with _t0 taint tracking.
// Optional control-taint propagation is enabled by defining IFT_SRAM_ARB_CTRL_TAINT_EN.
module ift_sram_arbiter
    import ift_sram_arb_pkg::*;
#(
    parameter int unsigned NumReq     = 2,
    parameter int unsigned AddrWidth  = 10,
    parameter int unsigned DataWidth  = 128,
    parameter int unsigned NumTaints  = 1,
    localparam int unsigned WidthBytes = DataWidth / 8
) (
    input  logic                                               clk_i,
    input  logic                                               rst_i,
    input  logic [NumReq-1:0]                                  req_i,
    input  logic [NumTaints-1:0][NumReq-1:0]                   req_i_t0,
    input  logic [NumReq-1:0]                                  we_i,
    input  logic [NumTaints-1:0][NumReq-1:0]                   we_i_t0,
    input  logic [NumReq-1:0][AddrWidth-1:0]                   addr_i,
    input  logic [NumTaints-1:0][NumReq-1:0][AddrWidth-1:0]    addr_i_t0,
    input  logic [NumReq-1:0][DataWidth-1:0]                   wdata_i,
    input  logic [NumTaints-1:0][NumReq-1:0][DataWidth-1:0]    wdata_i_t0,
    input  logic [NumReq-1:0][WidthBytes-1:0]                  be_i,
    input  logic [NumTaints-1:0][NumReq-1:0][WidthBytes-1:0]   be_i_t0,
    output logic [NumReq-1:0]                                  gnt_o,
    output logic [NumTaints-1:0][NumReq-1:0]                   gnt_o_t0,
    output logic [NumReq-1:0]                                  rvalid_o,
    output logic [NumTaints-1:0][NumReq-1:0]                   rvalid_o_t0,
    output logic [NumReq-1:0][DataWidth-1:0]                   rdata_o,
    output logic [NumTaints-1:0][NumReq-1:0][DataWidth-1:0]    rdata_o_t0,
    output logic                                               sram_req_o,
    output logic [NumTaints-1:0]                               sram_req_o_t0,
    output logic                                               sram_we_o,
    output logic [NumTaints-1:0]                               sram_we_o_t0,
    output logic [AddrWidth-1:0]                               sram_addr_o,
    output logic [NumTaints-1:0][AddrWidth-1:0]                sram_addr_o_t0,
    output logic [DataWidth-1:0]                               sram_wdata_o,
    output logic [NumTaints-1:0][DataWidth-1:0]                sram_wdata_o_t0,
    output logic [WidthBytes-1:0]                              sram_be_o,
    output logic [NumTaints-1:0][WidthBytes-1:0]               sram_be_o_t0,
    input  logic [DataWidth-1:0]                               sram_rdata_i,
    input  logic [NumTaints-1:0][DataWidth-1:0]                sram_rdata_i_t0
);

    req_idx_t          rr_ptr_q, rr_ptr_d;
    resp_t             resp_q, resp_d;
    logic [NumReq-1:0] pick_gnt;
    req_idx_t          pick_idx;
    logic              pick_v;
    logic [NumReq-1:0] gnt;
    logic              grant_v;
    logic              gnt_taint;

    ift_rr_picker #(
        .NumReq (NumReq)
    ) u_picker (
        .req_i   (req_i),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_v)
    );

    // Grants are combinational but must be silent while reset is held.
    assign gnt           = rst_i ? '0 : pick_gnt;
    assign grant_v       = pick_v & ~rst_i;
    assign gnt_o         = gnt;
    assign sram_req_o    = (|req_i) & ~rst_i;
    assign sram_req_o_t0 = {NumTaints{(|req_i_t0[0]) & ~rst_i}};

`ifdef IFT_SRAM_ARB_CTRL_TAINT_EN
    logic ptr_taint_q;

    // Once a tainted request has steered the pointer, every later grant depends on it.
    assign gnt_taint = (|req_i_t0[0]) | ptr_taint_q;
    assign gnt_o_t0  = {NumTaints{{NumReq{gnt_taint}}}};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_taint_q <= 1'b0;
        end else if (grant_v && (|req_i_t0[0])) begin
            ptr_taint_q <= 1'b1;
        end
    end
`else
    assign gnt_taint = 1'b0;
    assign gnt_o_t0  = '0;
`endif

    // SRAM-side mux from the granted requester, zero when nobody is granted.
    always_comb begin
        sram_we_o       = 1'b0;
        sram_addr_o     = '0;
        sram_wdata_o    = '0;
        sram_be_o       = '0;
        sram_we_o_t0    = '0;
        sram_addr_o_t0  = '0;
        sram_wdata_o_t0 = '0;
        sram_be_o_t0    = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (gnt[k]) begin
                sram_we_o          = we_i[k];
                sram_addr_o        = addr_i[k];
                sram_wdata_o       = wdata_i[k];
                sram_be_o          = be_i[k];
                sram_we_o_t0[0]    = we_i_t0[0][k];
                sram_addr_o_t0[0]  = addr_i_t0[0][k];
                sram_wdata_o_t0[0] = wdata_i_t0[0][k];
                sram_be_o_t0[0]    = be_i_t0[0][k];
            end
        end
    end

    always_comb begin
        rr_ptr_d     = grant_v ? next_ptr(pick_idx, NumReq) : rr_ptr_q;
        resp_d       = '0;
        resp_d.valid = grant_v;
        resp_d.id    = pick_idx;
        resp_d.taint = gnt_taint;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            resp_q   <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            resp_q   <= resp_d;
        end
    end

    // Response routed to the requester granted in the previous cycle.
    always_comb begin
        rvalid_o    = '0;
        rdata_o     = '0;
        rvalid_o_t0 = '0;
        rdata_o_t0  = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (resp_q.valid && (resp_q.id == IdxWidth'(k))) begin
                rvalid_o[k]       = 1'b1;
                rdata_o[k]        = sram_rdata_i;
                rvalid_o_t0[0][k] = resp_q.taint;
                rdata_o_t0[0][k]  = sram_rdata_i_t0[0] | {DataWidth{resp_q.taint}};
            end
        end
    end

endmodule

// File: tb/tb_ift_sram_arbiter.sv
// Self-checking bench for ift_sram_arbiter: vector table, directed corners, random vs model.
module tb_ift_sram_arbiter;

    localparam int N  = 2;
    localparam int AW = 10;
    localparam int DW = 128;
    localparam int BW = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                         rst;
    logic [N-1:0]                 req, we;
    logic [N-1:0][AW-1:0]         addr;
    logic [N-1:0][DW-1:0]         wdata;
    logic [N-1:0][BW-1:0]         be;
    logic [0:0][N-1:0]            req_t0, we_t0;
    logic [0:0][N-1:0][AW-1:0]    addr_t0;
    logic [0:0][N-1:0][DW-1:0]    wdata_t0;
    logic [0:0][N-1:0][BW-1:0]    be_t0;
    logic [N-1:0]                 gnt, rvalid;
    logic [0:0][N-1:0]            gnt_t0, rvalid_t0;
    logic [N-1:0][DW-1:0]         rdata;
    logic [0:0][N-1:0][DW-1:0]    rdata_t0;
    logic                         sram_req, sram_we;
    logic [0:0]                   sram_req_t0, sram_we_t0;
    logic [AW-1:0]                sram_addr;
    logic [0:0][AW-1:0]           sram_addr_t0;
    logic [DW-1:0]                sram_wdata;
    logic [0:0][DW-1:0]           sram_wdata_t0;
    logic [BW-1:0]                sram_be;
    logic [0:0][BW-1:0]           sram_be_t0;
    logic [DW-1:0]                sram_rdata;
    logic [0:0][DW-1:0]           sram_rdata_t0;

    ift_sram_arbiter #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW), .NumTaints(1)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .req_i(req), .req_i_t0(req_t0), .we_i(we), .we_i_t0(we_t0),
        .addr_i(addr), .addr_i_t0(addr_t0), .wdata_i(wdata), .wdata_i_t0(wdata_t0),
        .be_i(be), .be_i_t0(be_t0),
        .gnt_o(gnt), .gnt_o_t0(gnt_t0), .rvalid_o(rvalid), .rvalid_o_t0(rvalid_t0),
        .rdata_o(rdata), .rdata_o_t0(rdata_t0),
        .sram_req_o(sram_req), .sram_req_o_t0(sram_req_t0), .sram_we_o(sram_we), .sram_we_o_t0(sram_we_t0),
        .sram_addr_o(sram_addr), .sram_addr_o_t0(sram_addr_t0),
        .sram_wdata_o(sram_wdata), .sram_wdata_o_t0(sram_wdata_t0),
        .sram_be_o(sram_be), .sram_be_o_t0(sram_be_t0),
        .sram_rdata_i(sram_rdata), .sram_rdata_i_t0(sram_rdata_t0)
    );

    // Four-requester instance for pointer-wrap corner cases.
    logic                        rst4;
    logic [3:0]                  req4, gnt4, rvalid4;
    logic [0:0][3:0]             gnt4_t0, rvalid4_t0;
    logic [3:0][DW-1:0]          rdata4;
    logic [0:0][3:0][DW-1:0]     rdata4_t0;
    logic                        s4_req, s4_we;
    logic [0:0]                  s4_req_t0, s4_we_t0;
    logic [AW-1:0]               s4_addr;
    logic [0:0][AW-1:0]          s4_addr_t0;
    logic [DW-1:0]               s4_wdata;
    logic [0:0][DW-1:0]          s4_wdata_t0;
    logic [BW-1:0]               s4_be;
    logic [0:0][BW-1:0]          s4_be_t0;

    ift_sram_arbiter #(.NumReq(4), .AddrWidth(AW), .DataWidth(DW), .NumTaints(1)) u_dut4 (
        .clk_i(clk), .rst_i(rst4),
        .req_i(req4), .req_i_t0('0), .we_i('0), .we_i_t0('0),
        .addr_i('0), .addr_i_t0('0), .wdata_i('0), .wdata_i_t0('0),
        .be_i('0), .be_i_t0('0),
        .gnt_o(gnt4), .gnt_o_t0(gnt4_t0), .rvalid_o(rvalid4), .rvalid_o_t0(rvalid4_t0),
        .rdata_o(rdata4), .rdata_o_t0(rdata4_t0),
        .sram_req_o(s4_req), .sram_req_o_t0(s4_req_t0), .sram_we_o(s4_we), .sram_we_o_t0(s4_we_t0),
        .sram_addr_o(s4_addr), .sram_addr_o_t0(s4_addr_t0),
        .sram_wdata_o(s4_wdata), .sram_wdata_o_t0(s4_wdata_t0),
        .sram_be_o(s4_be), .sram_be_o_t0(s4_be_t0),
        .sram_rdata_i('0), .sram_rdata_i_t0('0)
    );

    // Behavioural SRAM with one-cycle read latency.
    logic [DW-1:0] mem [0:15];

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                            input logic [BW-1:0] bmask);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < BW; b++)
            if (bmask[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (!rst && sram_req) begin
            if (sram_we) mem[sram_addr[3:0]] <= merge(mem[sram_addr[3:0]], sram_wdata, sram_be);
            else         sram_rdata          <= mem[sram_addr[3:0]];
        end
    end

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model state: pointer, last grant, control taints.
    int m_ptr = 0;
    bit m_v   = 0;
    int m_idx = 0;
    bit m_gt  = 0;
    bit m_pt  = 0;

    // Inputs must already be applied (after negedge); checks outputs, then advances the model.
    task automatic cycle();
        int gi;
        bit gt;
        bit ev;
        logic [N-1:0] eg;
        logic [DW-1:0] ones;
        #1;
        ones = '1;
        if (rst) begin
            m_ptr = 0; m_v = 0; m_pt = 0; m_gt = 0;
        end
        gi = -1;
        if (!rst)
            for (int o = 0; o < N; o++)
                if (gi < 0 && req[(m_ptr + o) % N]) gi = (m_ptr + o) % N;
        eg = '0;
        if (gi >= 0) eg[gi] = 1'b1;
        chk("gnt", DW'(gnt), DW'(eg));
        chk("sram_req", DW'(sram_req), DW'(!rst && (|req)));
        chk("sram_req_t0", DW'(sram_req_t0), DW'(!rst && (|req_t0[0])));
        chk("sram_we", DW'(sram_we), (gi >= 0) ? DW'(we[gi]) : '0);
        chk("sram_addr", DW'(sram_addr), (gi >= 0) ? DW'(addr[gi]) : '0);
        chk("sram_wdata", sram_wdata, (gi >= 0) ? wdata[gi] : '0);
        chk("sram_be", DW'(sram_be), (gi >= 0) ? DW'(be[gi]) : '0);
        chk("sram_addr_t0", DW'(sram_addr_t0[0]), (gi >= 0) ? DW'(addr_t0[0][gi]) : '0);
        chk("sram_wdata_t0", sram_wdata_t0[0], (gi >= 0) ? wdata_t0[0][gi] : '0);
        chk("sram_be_t0", DW'(sram_be_t0[0]), (gi >= 0) ? DW'(be_t0[0][gi]) : '0);
`ifdef IFT_SRAM_ARB_CTRL_TAINT_EN
        gt = (|req_t0[0]) || m_pt;
`else
        gt = 1'b0;
`endif
        chk("gnt_t0", DW'(gnt_t0[0]), gt ? DW'({N{1'b1}}) : '0);
        for (int k = 0; k < N; k++) begin
            ev = m_v && (m_idx == k);
            chk($sformatf("rvalid%0d", k), DW'(rvalid[k]), DW'(ev));
            chk($sformatf("rdata%0d", k), rdata[k], ev ? sram_rdata : '0);
            chk($sformatf("rvalid_t0_%0d", k), DW'(rvalid_t0[0][k]), DW'(ev && m_gt));
            chk($sformatf("rdata_t0_%0d", k), rdata_t0[0][k],
                ev ? (sram_rdata_t0[0] | (m_gt ? ones : '0)) : '0);
        end
        if (!rst) begin
            m_v = (gi >= 0);
            m_idx = gi;
            if (gi >= 0) m_ptr = (gi + 1) % N;
            if (gi >= 0 && (|req_t0[0])) m_pt = 1'b1;
            m_gt = gt;
        end
    endtask

    typedef struct {
        bit            rst;
        logic [1:0]    req;
        logic [1:0]    we;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [DW-1:0] wd1;
        logic [1:0]    exp_gnt;
        logic [1:0]    exp_rvalid;
        logic [DW-1:0] exp_rdata0;
    } vec_t;

    function automatic vec_t mkv(bit r, logic [1:0] rq, logic [1:0] w, logic [AW-1:0] a0,
                                 logic [AW-1:0] a1, logic [DW-1:0] wd1, logic [1:0] eg,
                                 logic [1:0] ev, logic [DW-1:0] ed0);
        vec_t v;
        v.rst = r; v.req = rq; v.we = w; v.a0 = a0; v.a1 = a1; v.wd1 = wd1;
        v.exp_gnt = eg; v.exp_rvalid = ev; v.exp_rdata0 = ed0;
        return v;
    endfunction

    vec_t tbl[13];

    task automatic clear_inputs();
        req = '0; we = '0; addr = '0; wdata = '0; be = '1;
        req_t0 = '0; we_t0 = '0; addr_t0 = '0; wdata_t0 = '0; be_t0 = '0;
        sram_rdata_t0 = '0;
    endtask

    initial begin
        logic [DW-1:0] a5;
        a5 = {16{8'hA5}};
        rst = 1'b1; rst4 = 1'b1; req4 = '0;
        sram_rdata = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        clear_inputs();

        tbl[0]  = mkv(1, 2'b00, 2'b00, 0, 0, '0, 2'b00, 2'b00, '0);
        tbl[1]  = mkv(0, 2'b11, 2'b00, 0, 0, '0, 2'b01, 2'b00, '0);
        tbl[2]  = mkv(0, 2'b11, 2'b00, 0, 0, '0, 2'b10, 2'b01, '0);
        tbl[3]  = mkv(0, 2'b11, 2'b00, 0, 0, '0, 2'b01, 2'b10, '0);
        tbl[4]  = mkv(0, 2'b11, 2'b00, 0, 0, '0, 2'b10, 2'b01, '0);
        tbl[5]  = mkv(0, 2'b10, 2'b10, 0, 5, a5, 2'b10, 2'b10, '0);
        tbl[6]  = mkv(0, 2'b01, 2'b00, 5, 0, '0, 2'b01, 2'b10, '0);
        tbl[7]  = mkv(0, 2'b00, 2'b00, 0, 0, '0, 2'b00, 2'b01, a5);
        tbl[8]  = mkv(0, 2'b01, 2'b00, 5, 0, '0, 2'b01, 2'b00, '0);
        tbl[9]  = mkv(1, 2'b00, 2'b00, 0, 0, '0, 2'b00, 2'b00, '0);
        tbl[10] = mkv(0, 2'b00, 2'b00, 0, 0, '0, 2'b00, 2'b00, '0);
        tbl[11] = mkv(0, 2'b11, 2'b00, 0, 0, '0, 2'b01, 2'b00, '0);
        tbl[12] = mkv(0, 2'b00, 2'b00, 0, 0, '0, 2'b00, 2'b01, '0);

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            clear_inputs();
            rst = tbl[i].rst; req = tbl[i].req; we = tbl[i].we;
            addr[0] = tbl[i].a0; addr[1] = tbl[i].a1; wdata[1] = tbl[i].wd1;
            cycle();
            chk($sformatf("tbl%0d_gnt", i), DW'(gnt), DW'(tbl[i].exp_gnt));
            chk($sformatf("tbl%0d_rvalid", i), DW'(rvalid), DW'(tbl[i].exp_rvalid));
            chk($sformatf("tbl%0d_rdata0", i), rdata[0], tbl[i].exp_rdata0);
        end

        // Tainted request on requester 1 for a single grant cycle.
        @(negedge clk);
        clear_inputs();
        req = 2'b10; req_t0[0] = 2'b10;
        cycle();
`ifdef IFT_SRAM_ARB_CTRL_TAINT_EN
        chk("taint_gnt_now", DW'(gnt_t0[0]), DW'(2'b11));
`else
        chk("taint_gnt_now", DW'(gnt_t0[0]), '0);
`endif
        @(negedge clk);
        clear_inputs();
        sram_rdata_t0[0] = {$urandom, $urandom, $urandom, $urandom};
        cycle();
`ifdef IFT_SRAM_ARB_CTRL_TAINT_EN
        chk("taint_gnt_after", DW'(gnt_t0[0]), DW'(2'b11));
        chk("taint_rdata1", rdata_t0[0][1], {DW{1'b1}});
`else
        chk("taint_gnt_after", DW'(gnt_t0[0]), '0);
        chk("taint_rdata1", rdata_t0[0][1], sram_rdata_t0[0]);
`endif

        // Randomized traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            rst = ($urandom % 60 == 0);
            req = N'($urandom); we = N'($urandom);
            for (int k = 0; k < N; k++) begin
                addr[k]           = AW'($urandom % 16);
                wdata[k]          = {$urandom, $urandom, $urandom, $urandom};
                be[k]             = BW'($urandom);
                addr_t0[0][k]     = ($urandom % 4 == 0) ? AW'($urandom) : '0;
                wdata_t0[0][k]    = ($urandom % 4 == 0) ? {$urandom, $urandom, $urandom, $urandom} : '0;
                be_t0[0][k]       = BW'($urandom);
            end
            req_t0[0] = ($urandom % 8 == 0) ? N'($urandom) : '0;
            we_t0[0]  = N'($urandom);
            sram_rdata_t0[0] = {$urandom, $urandom, $urandom, $urandom};
            cycle();
        end

        // NumReq=4: pointer reaches 3, then request 0101 wraps to index 0, pointer becomes 1.
        @(negedge clk);
        rst4 = 1'b0; req4 = 4'b0100;
        #1 chk("n4_gnt_idx2", DW'(gnt4), DW'(4'b0100));
        @(negedge clk);
        req4 = 4'b0101;
        #1 chk("n4_gnt_wrap0", DW'(gnt4), DW'(4'b0001));
        chk("n4_rvalid2", DW'(rvalid4), DW'(4'b0100));
        @(negedge clk);
        req4 = 4'b1111;
        #1 chk("n4_gnt_ptr1", DW'(gnt4), DW'(4'b0010));
        chk("n4_rvalid0", DW'(rvalid4), DW'(4'b0001));
        @(negedge clk);
        req4 = '0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ift_sram_arbiter.md
IFT_SRAM_ARBITER -- requirements
Module: ift_sram_arbiter

Interface
REQ-001 SHALL take parameter NumReq, default 2, giving the number of requesters sharing one ift_sram port (range 2..8).
REQ-002 SHALL take parameter AddrWidth, default 10, giving the SRAM word-address width.
REQ-003 SHALL take parameter DataWidth, default 128, giving the data width.
REQ-004 SHALL take parameter NumTaints, default 1, giving the number of taint sets; only value 1 is supported.
REQ-005 SHALL define the dependent parameter WidthBytes = DataWidth/8; it is not overridden.
REQ-006 SHALL have port clk_i  in  1  single clock; one clock, all logic on its rising edge.
REQ-007 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have ports req_i, we_i  in  [NumReq]  per-requester request and write enable.
REQ-009 SHALL have ports addr_i, wdata_i, be_i  in  [NumReq][AddrWidth/DataWidth/WidthBytes]  per-requester address, write data and byte enable.
REQ-010 SHALL have ports gnt_o, rvalid_o  out  [NumReq]  grant and response valid.
REQ-011 SHALL have port rdata_o  out  [NumReq][DataWidth]  read data per requester.
REQ-012 SHALL have ports sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o  out  1/1/AddrWidth/DataWidth/WidthBytes  the SRAM-side request.
REQ-013 SHALL have port sram_rdata_i  in  DataWidth  SRAM read data (1-cycle latency).
REQ-014 SHALL carry a _t0 taint twin of every data and control port except clk_i and rst_i, with the same width prefixed by [NumTaints].

Function
REQ-015 SHALL grant combinationally: with one or more req_i set, exactly one gnt_o bit is set in the same cycle, and with none set no bit is set.
REQ-016 SHALL select the first requesting index at or after rr_ptr_q, wrapping modulo NumReq.
REQ-017 SHALL load rr_ptr_q with (granted index + 1) mod NumReq after a grant; NumReq-1 wraps to 0, and rr_ptr_q holds when no request is granted.
REQ-018 SHALL drive sram_req_o = |req_i, and mux sram_we/addr/wdata/be plus their taints from the granted requester; with no grant these outputs are 0.
REQ-019 SHALL assert rvalid_o[k] exactly one cycle after gnt_o[k] is asserted, for both reads and writes, using a registered response index resp_id_q and a valid flag resp_v_q.
REQ-020 SHALL drive rdata_o[k] = sram_rdata_i when rvalid_o[k] is set and 0 otherwise, and route rdata_o_t0 the same way.
REQ-021 SHALL accept back-to-back grants every cycle; with the single-cycle latency, no outstanding-request limit exists.
REQ-022 SHALL give a lone requester the grant regardless of rr_ptr_q.

Reset
REQ-023 SHALL, while rst_i is high, clear rr_ptr_q, resp_id_q, resp_v_q and all taint state, and drive gnt_o, rvalid_o and sram_req_o low.
REQ-024 SHALL drop a read in flight when reset asserts mid-read: no rvalid_o follows deassertion.
REQ-025 SHALL issue the first grant after reset from index 0 priority.

Configuration
REQ-026 SHALL, with IFT_SRAM_ARB_CTRL_TAINT_EN defined, set gnt_o_t0[k] = |req_i_t0 | ptr_taint_q.
REQ-027 SHALL, with IFT_SRAM_ARB_CTRL_TAINT_EN defined, make ptr_taint_q sticky: it sets on any grant cycle with |req_i_t0 and clears only on reset.
REQ-028 SHALL, with IFT_SRAM_ARB_CTRL_TAINT_EN defined, register the grant taint so that rvalid_o_t0 and all rdata_o_t0 bits of the responder OR in the grant taint of the previous cycle.
REQ-029 SHALL, without IFT_SRAM_ARB_CTRL_TAINT_EN, tie gnt_o_t0 and rvalid_o_t0 to 0 and take rdata_o_t0 solely from sram_rdata_i_t0.
REQ-030 SHALL propagate data and address taints through the mux in both configurations.

Structure
REQ-031 SHALL place the requester index typedef (width $clog2(NumReq)) and the response-register struct in package ift_sram_arb_pkg.
REQ-032 SHALL implement the round-robin selection in sub-module ift_rr_picker (inputs: request vector, pointer; outputs: one-hot grant, index).

Verification
REQ-033 SHALL cover: NumReq=2, reset then req_i=2'b11 for 4 cycles -> gnt_o sequence 01,10,01,10, and rvalid_o follows each grant one cycle later.
REQ-034 SHALL cover: requester 1 writes addr 5 with 0xA5.., then requester 0 reads addr 5 -> rdata_o[0]=0xA5.. with rvalid_o[0] one cycle after its grant.
REQ-035 SHALL cover: NumReq=4, rr_ptr_q=3, req_i=4'b0101 -> index 0 granted, then rr_ptr_q=1.
REQ-036 SHALL cover: rst_i pulsed in the cycle after a read grant -> rvalid_o stays 0, and the next grant restarts from index 0.
REQ-037 SHALL cover: macro defined, req_i_t0[1]=1 for one grant cycle -> gnt_o_t0 is all ones from then on and rdata_o_t0 of the responder is all ones; macro undefined -> gnt_o_t0=0 and rdata_o_t0 equals sram_rdata_i_t0.
